fetch_prefetch_queue: RTL and testbench

- Instruction-fetch front end; sits directly upstream of the IF/ID register.
- Issues sequential word fetches to instruction memory over a request/grant, in-order response bus, tags each returned word with its PC and buffers it in a small FIFO.
- Presents a valid/ready instruction stream to decode and drops the whole stream on a branch/jump redirect, including responses still in flight.

---
 rtl/fetch_prefetch_queue.sv | 204 ++++++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Fetch prefetch queue: issues sequential word fetches and buffers tagged words.
// Optional statistics outputs are enabled with the FETCH_STATS_EN macro.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flushed_words,
`endif
  input  logic        out_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  logic [31:0]   rdir_pc;
  logic [CW:0]   credit_used;
  logic          credit_ok;
  logic          issue;
  logic          accept;
  logic          drop;
  logic          pop;
  logic [CW-1:0] outst_after;

  assign rdir_pc     = redirect_pc & 32'hFFFF_FFFC;
  assign credit_used = {1'b0, count_q} + {1'b0, outst_q};
  assign credit_ok   = credit_used < DEPTH_W;

  // Request issue is purely combinational and never raised during a redirect.
  always_comb begin
    mem_req  = ~rst & enable & ~redirect & credit_ok;
    mem_addr = fetch_pc_q;
    issue    = mem_req & mem_gnt;
  end

  // Classify the returning word and the head handshake.
  always_comb begin
    accept    = 1'b0;
    drop      = 1'b0;
    out_valid = (count_q != '0);
    pop       = out_valid & out_ready & enable & ~redirect;
    if (mem_rvalid && !redirect) begin
      if (disc_q == '0) begin
        accept = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Head fields are read from the registered storage, NOP when empty.
  always_comb begin
    out_instr = NOP_INSTR;
    out_pc    = 32'h0;
    if (out_valid) begin
      out_instr = instr_q[rptr_q];
      out_pc    = pc_q[rptr_q];
    end
  end

  // Outstanding count: +1 per grant, -1 per response (never below zero).
  always_comb begin
    outst_after = outst_q;
    if (mem_rvalid && outst_q != '0) begin
      outst_after = outst_q - CW'(1);
    end
    outst_d = outst_after + CW'(issue);
  end

  // Next-state for PCs, pointers, occupancy and the stale-response counter.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    disc_d     = disc_q;
    if (redirect) begin
      fetch_pc_d = rdir_pc;
      resp_pc_d  = rdir_pc;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      disc_d     = outst_after;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (accept) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wptr_d    = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      if (drop) begin
        disc_d = disc_q - CW'(1);
      end
      count_d = count_q + CW'(accept) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
    end
  end

  // Entry storage: written only when a live word is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      instr_q[wptr_q] <= mem_rdata;
      pc_q[wptr_q]    <= resp_pc_q;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] flush_inc;

  // Words lost to a redirect: flushed entries, the word in the redirect
  // cycle, and every later stale response.
  always_comb begin
    flush_inc = 32'h0;
    if (redirect) begin
      flush_inc = 32'(count_q) + 32'(mem_rvalid);
    end else if (drop) begin
      flush_inc = 32'h1;
    end
  end

  // Free-running statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles  <= 32'h0;
      flushed_words <= 32'h0;
    end else begin
      if (out_ready && enable && !out_valid) begin
        stall_cycles <= stall_cycles + 32'h1;
      end
      flushed_words <= flushed_words + flush_inc;
    end
  end
`endif

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    (accept && !pop) |-> (count_q != DEPTH_C)
  );

  a_rvalid_tracked: assert property (
    @(posedge clk) disable iff (rst)
    mem_rvalid |-> (outst_q != '0)
  );

  a_disc_le_outst: assert property (
    @(posedge clk) disable iff (rst)
    disc_q <= outst_q
  );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue with a random in-order memory.
// Expected stream: per redirect epoch, words from the target upward.
module tb_fetch_prefetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flushed_words;
`endif

  fetch_prefetch_queue #(
    .DEPTH(DEPTH),
    .RESET_PC(32'h0),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
`ifdef FETCH_STATS_EN
    .stall_cycles(stall_cycles),
    .flushed_words(flushed_words),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned epoch;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        pend[$];
  ent_t        exp_q[$];
  req_t        drv_resp;
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned epoch = 0;
  logic [31:0] exp_fetch = 32'h0;
  int          p_gnt, p_ready, p_en, p_redir;
  int unsigned lat_max;
  int          first_valid = -1;
  int          grants = 0;
  bit          chk_flush = 0;
  bit          force_redir = 0;
  logic [31:0] force_pc = 32'h0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    enable      = ($urandom_range(99) < p_en);
    out_ready   = ($urandom_range(99) < p_ready);
    mem_gnt     = ($urandom_range(99) < p_gnt);
    redirect    = ($urandom_range(99) < p_redir);
    redirect_pc = $urandom;
    if (force_redir) begin
      redirect    = 1'b1;
      redirect_pc = force_pc;
      force_redir = 0;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      drv_resp   = pend.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = memfn(drv_resp.addr);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  // Monitor: compares DUT behaviour with the epoch/stream model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_mem_req", {31'b0, mem_req}, 32'h0);
      check("rst_out_valid", {31'b0, out_valid}, 32'h0);
      check("rst_out_instr", out_instr, NOP);
      check("rst_out_pc", out_pc, 32'h0);
    end else begin
      int outst;
      bit exp_req;
      outst = pend.size() + (mem_rvalid ? 1 : 0);
      if (chk_flush) begin
        check("flush_empty", {31'b0, out_valid}, 32'h0);
        chk_flush = 0;
      end
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      if (!out_valid) begin
        if (out_instr !== NOP) check("empty_instr", out_instr, NOP);
        if (out_pc !== 32'h0) check("empty_pc", out_pc, 32'h0);
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      exp_req = enable && !redirect && (exp_q.size() + outst < DEPTH);
      check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
      if (out_valid && out_ready && enable && !redirect && exp_q.size() > 0) begin
        ent_t e;
        e = exp_q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_instr", out_instr, e.instr);
      end
      if (mem_req && mem_gnt) begin
        req_t r;
        check("mem_addr", mem_addr, exp_fetch);
        r.addr  = exp_fetch;
        r.due   = cyc + $urandom_range(lat_max, 1);
        r.epoch = epoch;
        pend.push_back(r);
        exp_fetch = exp_fetch + 32'd4;
        grants++;
      end
      if (mem_rvalid && !redirect && drv_resp.epoch == epoch) begin
        ent_t e;
        e.pc    = drv_resp.addr;
        e.instr = memfn(drv_resp.addr);
        exp_q.push_back(e);
      end
      if (redirect) begin
        exp_q.delete();
        epoch++;
        exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        chk_flush = 1;
      end
    end
  end

  initial begin
    rst = 1'b1;
    p_gnt = 100; p_ready = 100; p_en = 100; p_redir = 0; lat_max = 1;
    enable = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    out_ready = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    drv_resp = '{addr: 32'h0, due: 0, epoch: 0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 1;
    drive();

    // Streaming: grant every cycle, 1-cycle response latency.
    repeat (11) step();
    check("first_valid_cycle", 32'(first_valid), 32'd3);

    // Redirect to 0x102, then hold out_ready low: exactly DEPTH fetches.
    force_redir = 1; force_pc = 32'h0000_0102;
    step();
    p_ready = 0;
    grants = 0;
    repeat (10) step();
    check("stall_grants", 32'(grants), 32'(DEPTH));
    @(negedge clk);
    check("stall_head_pc", out_pc, 32'h0000_0100);
    check("stall_req_off", {31'b0, mem_req}, 32'h0);
    p_ready = 100;
    repeat (10) step();

    // Randomized traffic with stalls, enable gaps and redirects.
    p_gnt = 70; p_ready = 70; p_en = 85; p_redir = 5; lat_max = 4;
    repeat (3000) step();

    // Quiet drain.
    p_redir = 0; p_en = 100; p_ready = 100; p_gnt = 0;
    repeat (20) step();
    @(negedge clk);
    check("drain_empty", {31'b0, out_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
